// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: ALU control codes and data width.
// Imported by the ALU, its interface and the ALU control decoder.
package mips_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_NOR  = 4'b1100
  } alu_op_t;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/result bundle between the execute stage and the ALU datapath.
// The master drives op and operands; the slave returns flags and result.
interface mips_alu_if;
  import mips_pkg::*;

  alu_op_t           op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              overflow;

  modport master (
    output op, a, b,
    input  result, zero, overflow
  );

  modport slave (
    input  op, a, b,
    output result, zero, overflow
  );

endinterface

// File: rtl/mips_alu_core.sv
// Combinational MIPS ALU: result, zero and signed-overflow flags.
// Undefined control codes yield a zero result with no overflow.
module mips_alu_core
  import mips_pkg::*;
(
  mips_alu_if.slave bus
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [4:0]        shamt;
  logic              add_ovf;
  logic              sub_ovf;

  assign sum   = bus.a + bus.b;
  assign diff  = bus.a - bus.b;
  assign shamt = bus.a[4:0];

  assign add_ovf = (bus.a[DATA_W-1] == bus.b[DATA_W-1])
                 & (sum[DATA_W-1] != bus.a[DATA_W-1]);
  assign sub_ovf = (bus.a[DATA_W-1] != bus.b[DATA_W-1])
                 & (diff[DATA_W-1] != bus.a[DATA_W-1]);

  always_comb begin
    bus.result   = '0;
    bus.overflow = 1'b0;
    unique case (bus.op)
      ALU_AND:  bus.result = bus.a & bus.b;
      ALU_OR:   bus.result = bus.a | bus.b;
      ALU_ADD: begin
        bus.result   = sum;
        bus.overflow = add_ovf;
      end
      ALU_XOR:  bus.result = bus.a ^ bus.b;
      ALU_SLL:  bus.result = bus.b << shamt;
      ALU_SRL:  bus.result = bus.b >> shamt;
      ALU_SUB: begin
        bus.result   = diff;
        bus.overflow = sub_ovf;
      end
      // true signed compare, immune to overflow of a - b
      ALU_SLT:
        bus.result = {{(DATA_W-1){1'b0}},
                      $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU:
        bus.result = {{(DATA_W-1){1'b0}}, bus.a < bus.b};
      ALU_SRA:
        bus.result = DATA_W'($signed(bus.b) >>> shamt);
      ALU_NOR:  bus.result = ~(bus.a | bus.b);
      default: begin
        bus.result   = '0;
        bus.overflow = 1'b0;
      end
    endcase
  end

  assign bus.zero = (bus.result == '0);

endmodule

// File: rtl/mips_alu.sv
// Execute-stage ALU with registered result, zero and overflow flags.
// One cycle latency; reset forces a zero result.
module mips_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             zero,
  output logic             overflow
);

  mips_alu_if core_if ();

  assign core_if.op = alu_op_t'(opCode);
  assign core_if.a  = A;
  assign core_if.b  = B;

  mips_alu_core u_core (
    .bus (core_if)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_Out  <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      ALU_Out  <= core_if.result;
      zero     <= core_if.zero;
      overflow <= core_if.overflow;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu.
// Expected values queue at drive time and are compared one cycle later.
module tb_mips_alu;
  import mips_pkg::*;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        z;
    logic        v;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        z;
    logic        v;
    int          idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out;
  logic        zero;
  logic        overflow;

  int n_tests;
  int n_fail;

  exp_t q[$];
  vec_t vecs[$];

  mips_alu_if bus ();

  mips_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .opCode   (bus.op),
    .A        (bus.a),
    .B        (bus.b),
    .ALU_Out  (alu_out),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] o, input logic z,
                     input logic v);
    vec_t t;
    t.rst = r; t.op = op; t.a = a; t.b = b;
    t.out = o; t.z = z; t.v = v;
    vecs.push_back(t);
  endtask

  task automatic compare_front();
    exp_t e;
    string s;
    e = q.pop_front();
    s = $sformatf("v%0d", e.idx);
    check({s, ".out"}, alu_out, e.out);
    check({s, ".zero"}, {31'd0, zero}, {31'd0, e.z});
    check({s, ".ovf"}, {31'd0, overflow}, {31'd0, e.v});
  endtask

  localparam logic [31:0] LA = 32'hF0F0_0004;
  localparam logic [31:0] LB = 32'h8000_00FF;

  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;

    add(1, 4'b0010, 5, 3, 0, 1, 0);
    add(1, 4'b0010, 5, 3, 0, 1, 0);
    add(0, 4'b0010, 5, 3, 8, 0, 0);
    add(0, 4'b0010, 1000, 200, 1200, 0, 0);
    add(0, 4'b0110, 1000, 200, 800, 0, 0);
    add(0, 4'b0110, 1000, 2000, 32'hFFFF_FC18, 0, 0);
    add(0, 4'b0110, 1000, 1000, 0, 1, 0);
    add(0, 4'b0010, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 1);
    add(0, 4'b0110, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 1);
    add(0, 4'b0111, 32'hFFFF_FFFF, 1, 1, 0, 0);
    add(0, 4'b1000, 32'hFFFF_FFFF, 1, 0, 1, 0);
    add(0, 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1, 0);
    add(0, 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0);
    add(0, 4'b0000, LA, LB, 32'h8000_0004, 0, 0);
    add(0, 4'b0001, LA, LB, 32'hF0F0_00FF, 0, 0);
    add(0, 4'b0011, LA, LB, 32'h70F0_00FB, 0, 0);
    add(0, 4'b1100, LA, LB, 32'h0F0F_FF00, 0, 0);
    add(0, 4'b0100, LA, LB, 32'h0000_0FF0, 0, 0);
    add(0, 4'b0101, LA, LB, 32'h0800_000F, 0, 0);
    add(0, 4'b1001, LA, LB, 32'hF800_000F, 0, 0);
    add(0, 4'b1111, LA, LB, 0, 1, 0);
    add(0, 4'b1010, 7, 9, 0, 1, 0);
    add(0, 4'b0100, 32'h0000_0020, 32'h1234_5678,
        32'h1234_5678, 0, 0);
    add(0, 4'b1001, 32'h0000_001F, 32'h8000_0000,
        32'hFFFF_FFFF, 0, 0);
    add(0, 4'b0010, 32'h8000_0000, 32'h8000_0000, 0, 1, 1);
    add(0, 4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
        32'h8000_0000, 0, 1);
    add(0, 4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 1, 0);
    add(1, 4'b0010, 32'h7FFF_FFFF, 1, 0, 1, 0);
    add(0, 4'b0010, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (q.size() > 0) compare_front();
      rst    = vecs[i].rst;
      bus.op = alu_op_t'(vecs[i].op);
      bus.a  = vecs[i].a;
      bus.b  = vecs[i].b;
      e.out  = vecs[i].out;
      e.z    = vecs[i].z;
      e.v    = vecs[i].v;
      e.idx  = i;
      q.push_back(e);
    end

    for (int k = 0; k < 4 && q.size() > 0; k++) begin
      @(negedge clk);
      compare_front();
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
